// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: opcodes, control-word bit
// positions, ALUOp encodings and the packed ID/EX register layout.
package id_ex_stage_pkg;

    // Supported opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    // Control word {regDst,ALUSrc,memtoReg,regWrite,memRead,memWrite,branch,ALUOp1,ALUOp0}
    localparam int unsigned CTRL_W          = 9;
    localparam int unsigned CTRL_REG_DST    = 8;
    localparam int unsigned CTRL_ALU_SRC    = 7;
    localparam int unsigned CTRL_MEM_TO_REG = 6;
    localparam int unsigned CTRL_REG_WRITE  = 5;
    localparam int unsigned CTRL_MEM_READ   = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 3;
    localparam int unsigned CTRL_BRANCH     = 2;
    localparam int unsigned CTRL_ALU_OP1    = 1;
    localparam int unsigned CTRL_ALU_OP0    = 0;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    // Contents of the ID/EX pipeline register; all-zero is a bubble
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc4;
        logic [31:0]       rdata1;
        logic [31:0]       rdata2;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } id_ex_t;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect_unit.sv
// Combinational load-use hazard detector: an instruction in ID that reads the
// destination of a load sitting in EX must wait one cycle.
module hazard_detect_unit (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       hazard_o
);

    // Register 0 never carries a dependency
    always_comb begin
        hazard_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != 5'd0) && id_valid_i &&
                   ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash, sticky illegal
// opcode flag and a saturating stall-cycle counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned StallCntWidth = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [5:0]               id_op,
    input  logic [CTRL_W-1:0]        id_ctrl,
    input  logic [31:0]              id_pc4,
    input  logic [31:0]              id_rdata1,
    input  logic [31:0]              id_rdata2,
    input  logic [31:0]              id_imm,
    input  logic [4:0]               id_rs,
    input  logic [4:0]               id_rt,
    input  logic [4:0]               id_rd,
    input  logic                     flush,
    output logic                     stall,
    output logic                     illegal_op,
    output logic                     ex_valid,
    output logic [CTRL_W-1:0]        ex_ctrl,
    output logic [31:0]              ex_pc4,
    output logic [31:0]              ex_rdata1,
    output logic [31:0]              ex_rdata2,
    output logic [31:0]              ex_imm,
    output logic [4:0]               ex_rs,
    output logic [4:0]               ex_rt,
    output logic [4:0]               ex_rd,
    output logic [StallCntWidth-1:0] stall_count
);

    id_ex_t                   pipe_q, pipe_d;
    logic                     illegal_op_q, illegal_op_d;
    logic [StallCntWidth-1:0] stall_count_q, stall_count_d;
    logic                     hazard;
    logic                     id_illegal;

    hazard_detect_unit u_hazard (
        .ex_valid_i    (pipe_q.valid),
        .ex_mem_read_i (pipe_q.ctrl[CTRL_MEM_READ]),
        .ex_rt_i       (pipe_q.rt),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .hazard_o      (hazard)
    );

    // Stall request to the front end; a flush or reset overrides the hazard
    always_comb begin
        stall      = hazard && !flush && !reset;
        id_illegal = id_valid && !op_supported(id_op);
    end

    // Next pipeline contents: flush > hazard > illegal > normal load
    always_comb begin
        pipe_d        = '0;
        illegal_op_d  = illegal_op_q;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + StallCntWidth'(1);
        end
        if (flush || hazard || !id_valid) begin
            pipe_d = '0;
        end else if (id_illegal) begin
            pipe_d       = '0;
            illegal_op_d = 1'b1;
        end else begin
            pipe_d.valid  = 1'b1;
            pipe_d.ctrl   = id_ctrl;
            pipe_d.pc4    = id_pc4;
            pipe_d.rdata1 = id_rdata1;
            pipe_d.rdata2 = id_rdata2;
            pipe_d.imm    = id_imm;
            pipe_d.rs     = id_rs;
            pipe_d.rt     = id_rt;
            pipe_d.rd     = id_rd;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_q        <= '0;
            illegal_op_q  <= 1'b0;
            stall_count_q <= '0;
        end else begin
            pipe_q        <= pipe_d;
            illegal_op_q  <= illegal_op_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Registered outputs only; nothing from id_* reaches ex_* combinationally
    always_comb begin
        ex_valid    = pipe_q.valid;
        ex_ctrl     = pipe_q.ctrl;
        ex_pc4      = pipe_q.pc4;
        ex_rdata1   = pipe_q.rdata1;
        ex_rdata2   = pipe_q.rdata2;
        ex_imm      = pipe_q.imm;
        ex_rs       = pipe_q.rs;
        ex_rt       = pipe_q.rt;
        ex_rd       = pipe_q.rd;
        illegal_op  = illegal_op_q;
        stall_count = stall_count_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts each edge's
// register contents into a scoreboard queue that is drained after the edge.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [8:0] CtrlR  = 9'b100100010;
    localparam logic [8:0] CtrlLw = 9'b011110000;
    localparam logic [8:0] CtrlSw = 9'b010001000;
    localparam logic [8:0] CtrlBq = 9'b000000101;

    logic        clock = 1'b0;
    logic        reset, id_valid, flush;
    logic [5:0]  id_op;
    logic [8:0]  id_ctrl;
    logic [31:0] id_pc4, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        stall, illegal_op, ex_valid;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] stall_count;

    // Narrow-counter copy so counter saturation is reachable in a short run
    logic        s_stall, s_illegal_op, s_ex_valid;
    logic [8:0]  s_ex_ctrl;
    logic [31:0] s_ex_pc4, s_ex_rdata1, s_ex_rdata2, s_ex_imm;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
    logic [3:0]  s_stall_count;

    always #5 clock = ~clock;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op),
        .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .illegal_op(illegal_op), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_count(stall_count)
    );

    id_ex_stage #(.StallCntWidth(4)) dut_sat (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op(id_op),
        .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(s_stall), .illegal_op(s_illegal_op), .ex_valid(s_ex_valid),
        .ex_ctrl(s_ex_ctrl), .ex_pc4(s_ex_pc4), .ex_rdata1(s_ex_rdata1),
        .ex_rdata2(s_ex_rdata2), .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
        .ex_rd(s_ex_rd), .stall_count(s_stall_count)
    );

    typedef struct {
        logic        valid;
        logic [8:0]  ctrl;
        logic [31:0] pc4, r1, r2, imm;
        logic [4:0]  rs, rt, rd;
        logic        ill;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID slot, predict the edge, then compare after the edge
    task automatic step(input string tag, input logic rst, input logic fl, input logic v,
                        input logic [5:0] op, input logic [8:0] ctrl,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        logic        hz, st, legal;
        logic [31:0] pc4, r1, r2, imm;
        exp_t        n, e;
        pc4 = $urandom; r1 = $urandom; r2 = $urandom; imm = $urandom;
        @(negedge clock);
        reset = rst; flush = fl; id_valid = v; id_op = op; id_ctrl = ctrl;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_pc4 = pc4; id_rdata1 = r1; id_rdata2 = r2; id_imm = imm;
        #1;
        hz    = m.valid && m.ctrl[4] && (m.rt != 5'd0) && v && ((m.rt == rs) || (m.rt == rt));
        st    = hz && !fl && !rst;
        legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4);
        check_eq({tag, ":stall"}, 32'(stall), 32'(st));
        check_eq({tag, ":stall_s"}, 32'(s_stall), 32'(st));

        n = m;
        if (rst) begin
            n = '{default: '0};
        end else begin
            if (st) begin
                if (m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
                if (m.cnt_s != 4'hF) n.cnt_s = m.cnt_s + 4'd1;
            end
            if (fl || hz || !v || !legal) begin
                n.valid = 1'b0; n.ctrl = '0; n.pc4 = '0; n.r1 = '0; n.r2 = '0;
                n.imm = '0; n.rs = '0; n.rt = '0; n.rd = '0;
                if (!fl && !hz && v && !legal) n.ill = 1'b1;
            end else begin
                n.valid = 1'b1; n.ctrl = ctrl; n.pc4 = pc4; n.r1 = r1; n.r2 = r2;
                n.imm = imm; n.rs = rs; n.rt = rt; n.rd = rd;
            end
        end
        sb.push_back(n);
        m = n;

        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_eq({tag, ":ex_valid"}, 32'(ex_valid), 32'(e.valid));
        check_eq({tag, ":ex_ctrl"}, 32'(ex_ctrl), 32'(e.ctrl));
        check_eq({tag, ":ex_pc4"}, ex_pc4, e.pc4);
        check_eq({tag, ":ex_rdata1"}, ex_rdata1, e.r1);
        check_eq({tag, ":ex_rdata2"}, ex_rdata2, e.r2);
        check_eq({tag, ":ex_imm"}, ex_imm, e.imm);
        check_eq({tag, ":ex_rs"}, 32'(ex_rs), 32'(e.rs));
        check_eq({tag, ":ex_rt"}, 32'(ex_rt), 32'(e.rt));
        check_eq({tag, ":ex_rd"}, 32'(ex_rd), 32'(e.rd));
        check_eq({tag, ":illegal_op"}, 32'(illegal_op), 32'(e.ill));
        check_eq({tag, ":stall_count"}, 32'(stall_count), 32'(e.cnt));
        check_eq({tag, ":stall_count_s"}, 32'(s_stall_count), 32'(e.cnt_s));
    endtask

    initial begin
        m = '{default: '0};
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_op = '0; id_ctrl = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_pc4 = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0;

        step("reset0", 1, 0, 1, OP_RTYPE, CtrlR, 1, 2, 3);
        step("reset1", 1, 0, 1, OP_LW, CtrlLw, 1, 5, 0);
        // First instruction after reset is captured on the first free edge
        step("rtype", 0, 0, 1, OP_RTYPE, CtrlR, 1, 2, 3);
        // Load-use: one stall, bubble, then the held add advances
        step("lw5", 0, 0, 1, OP_LW, CtrlLw, 1, 5, 0);
        step("use_stall", 0, 0, 1, OP_RTYPE, CtrlR, 5, 6, 7);
        step("use_go", 0, 0, 1, OP_RTYPE, CtrlR, 5, 6, 7);
        // Dependency through rt
        step("lw8", 0, 0, 1, OP_LW, CtrlLw, 2, 8, 0);
        step("use_rt", 0, 0, 1, OP_SW, CtrlSw, 3, 8, 0);
        step("use_rt_go", 0, 0, 1, OP_SW, CtrlSw, 3, 8, 0);
        // Register 0 never stalls
        step("lw0", 0, 0, 1, OP_LW, CtrlLw, 1, 0, 0);
        step("use_r0", 0, 0, 1, OP_RTYPE, CtrlR, 0, 4, 9);
        // Flush and hazard together: no stall, bubble, counter unchanged
        step("lw5b", 0, 0, 1, OP_LW, CtrlLw, 1, 5, 0);
        step("flush_hz", 0, 1, 1, OP_RTYPE, CtrlR, 5, 6, 7);
        // id_valid=0 loads a bubble
        step("noval", 0, 0, 0, OP_BEQ, CtrlBq, 1, 2, 0);
        step("beq", 0, 0, 1, OP_BEQ, CtrlBq, 3, 4, 0);
        // Illegal opcode with flush must not set the sticky flag
        step("ill_flush", 0, 1, 1, 6'd2, CtrlR, 1, 2, 3);
        step("ill", 0, 0, 1, 6'd2, CtrlR, 1, 2, 3);
        step("ill_hold0", 0, 0, 1, OP_RTYPE, CtrlR, 9, 10, 11);
        step("ill_hold1", 0, 0, 1, OP_SW, CtrlSw, 12, 13, 0);
        // Reset asserted mid-stall clears everything and suppresses stall
        step("lw5c", 0, 0, 1, OP_LW, CtrlLw, 1, 5, 0);
        step("rst_mid", 1, 0, 1, OP_RTYPE, CtrlR, 5, 6, 7);
        step("post_rst", 0, 0, 1, OP_RTYPE, CtrlR, 5, 6, 7);
        // Chained lw r5,(r5) stalls every other cycle and drives the counters
        for (int i = 0; i < 40; i++) begin
            step("sat", 0, 0, 1, OP_LW, CtrlLw, 5, 5, 0);
        end
        for (int i = 0; i < 6; i++) begin
            step("rand", 0, 0, 1, OP_RTYPE, CtrlR, 5'($urandom), 5'($urandom), 5'($urandom));
        end
        step("final_rst", 1, 0, 1, OP_LW, CtrlLw, 1, 5, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
